// File: rtl/johnson_pkg.sv
// ----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for Johnson-code handling: the monitor FSM state type,
// the saturation limit of the error counter, and width-generic helper
// functions (successor, legality, index decode). Packages cannot take
// parameters, so each function works on a MAX_N-bit vector and receives the
// active code width n as an argument. Bits at or above n are ignored.
// ----------------------------------------------------------------------------
package johnson_pkg;

    localparam int         MAX_N       = 32;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        TRACK = 2'd2
    } jstate_e;

    // Successor in the Johnson sequence: shift left, feed back inverted MSB.
    function automatic logic [MAX_N-1:0] johnson_next(input logic [MAX_N-1:0] q,
                                                     input int               n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 1; i < MAX_N; i++) begin
            if (i < n) r[i] = q[i-1];
        end
        r[0] = ~q[n-1];
        return r;
    endfunction

    // A Johnson code has at most one 0/1 boundary between adjacent bits.
    function automatic logic johnson_legal(input logic [MAX_N-1:0] q,
                                           input int               n);
        int edges;
        edges = 0;
        for (int i = 0; i < MAX_N - 1; i++) begin
            if ((i < n - 1) && (q[i] != q[i+1])) edges++;
        end
        return (edges <= 1);
    endfunction

    // Fill phase (MSB=0) counts ones; drain phase (MSB=1) counts zeros past N.
    function automatic logic [7:0] johnson_index(input logic [MAX_N-1:0] q,
                                                 input int               n);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if ((i < n) && q[i]) ones++;
        end
        if (q[n-1]) return 8'(n + (n - ones));
        else        return 8'(ones);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// ----------------------------------------------------------------------------
// johnson_decode
// Combinational reader for an N-bit Johnson code.
//   q_i     : Johnson code under test
//   legal_o : 1 when q_i is one of the 2N legal Johnson codes
//   idx_o   : state index 0..2N-1 (only meaningful when legal_o=1)
// ----------------------------------------------------------------------------
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  q_i,
    output logic          legal_o,
    output logic [IW-1:0] idx_o
);

    logic [MAX_N-1:0] q_ext;
    logic [7:0]       idx_full;

    assign q_ext    = MAX_N'(q_i);
    assign legal_o  = johnson_legal(q_ext, N);
    assign idx_full = johnson_index(q_ext, N);
    assign idx_o    = IW'(idx_full);

endmodule

// File: rtl/johnson_code_monitor.sv
// ----------------------------------------------------------------------------
// johnson_code_monitor
// Samples a Johnson-coded bus on enabled edges, decodes it to a state index,
// and checks legality and sequence continuity.
//   CLK     : clock, rising edge
//   CLR     : asynchronous active-high reset
//   EN      : sample enable
//   Q_IN    : Johnson code under test
//   IDX     : index of last legal sample
//   VALID   : last sample was legal
//   LOCKED  : FSM is in TRACK
//   WRAP    : pulse, all-zeros code accepted as expected successor in TRACK
//   SEQ_ERR : pulse, legal but unexpected code in TRACK
//   ILLEGAL : pulse, non-Johnson code sampled
//   ERR_CNT : saturating count of SEQ_ERR + ILLEGAL events
// ----------------------------------------------------------------------------
module johnson_code_monitor
    import johnson_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_LEN = 2,
    parameter int IW       = $clog2(2 * N)
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          EN,
    input  logic [N-1:0]  Q_IN,
    output logic [IW-1:0] IDX,
    output logic          VALID,
    output logic          LOCKED,
    output logic          WRAP,
    output logic          SEQ_ERR,
    output logic          ILLEGAL,
    output logic [7:0]    ERR_CNT
);

    localparam int MW = $clog2(LOCK_LEN + 1);

    jstate_e       state_q;
    logic [N-1:0]  exp_q;
    logic [N-1:0]  exp_d;
    logic [MW-1:0] mcnt_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;
    logic          locked_q;
    logic          wrap_q;
    logic          seq_err_q;
    logic          illegal_q;
    logic [7:0]    err_cnt_q;

    logic          legal;
    logic [IW-1:0] dec_idx;
    logic          match;
    logic          lock_hit;

    johnson_decode #(.N(N), .IW(IW)) u_decode (
        .q_i     (Q_IN),
        .legal_o (legal),
        .idx_o   (dec_idx)
    );

    // Whatever is sampled now, the following sample should be its successor.
    assign exp_d    = N'(johnson_next(MAX_N'(Q_IN), N));
    assign match    = (Q_IN == exp_q);
    assign lock_hit = ((int'(mcnt_q) + 1) == LOCK_LEN);

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            mcnt_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            wrap_q    <= 1'b0;
            seq_err_q <= 1'b0;
            illegal_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            // Pulses last one cycle and clear even when EN=0.
            wrap_q    <= 1'b0;
            seq_err_q <= 1'b0;
            illegal_q <= 1'b0;

            if (EN) begin
                if (!legal) begin
                    // IDX keeps the last legal index.
                    illegal_q <= 1'b1;
                    valid_q   <= 1'b0;
                    state_q   <= IDLE;
                    locked_q  <= 1'b0;
                    if (err_cnt_q != ERR_CNT_MAX) err_cnt_q <= err_cnt_q + 8'd1;
                end else begin
                    idx_q   <= dec_idx;
                    valid_q <= 1'b1;
                    exp_q   <= exp_d;
                    case (state_q)
                        IDLE: begin
                            state_q <= HUNT;
                            mcnt_q  <= '0;
                        end
                        HUNT: begin
                            if (match) begin
                                mcnt_q <= MW'(int'(mcnt_q) + 1);
                                if (lock_hit) begin
                                    state_q  <= TRACK;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                mcnt_q <= '0;
                            end
                        end
                        TRACK: begin
                            if (match) begin
                                wrap_q <= (Q_IN == '0);
                            end else begin
                                // A stalled (repeated) code also lands here.
                                seq_err_q <= 1'b1;
                                state_q   <= HUNT;
                                locked_q  <= 1'b0;
                                mcnt_q    <= '0;
                                if (err_cnt_q != ERR_CNT_MAX) err_cnt_q <= err_cnt_q + 8'd1;
                            end
                        end
                        default: begin
                            state_q  <= IDLE;
                            locked_q <= 1'b0;
                            mcnt_q   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign IDX     = idx_q;
    assign VALID   = valid_q;
    assign LOCKED  = locked_q;
    assign WRAP    = wrap_q;
    assign SEQ_ERR = seq_err_q;
    assign ILLEGAL = illegal_q;
    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_johnson_code_monitor.sv
// ----------------------------------------------------------------------------
// tb_johnson_code_monitor
// Directed stimulus for N=4, LOCK_LEN=2. The driver changes inputs on the
// falling edge and queues the hand-computed response for the coming rising
// edge; the monitor pops one entry per rising edge and compares.
// ----------------------------------------------------------------------------
module tb_johnson_code_monitor;

    localparam int N  = 4;
    localparam int IW = 3;

    typedef struct {
        logic [IW-1:0] idx;
        logic          valid;
        logic          locked;
        logic          wrap;
        logic          seq_err;
        logic          illegal;
        logic [7:0]    cnt;
    } exp_t;

    logic          clk;
    logic          clr;
    logic          en;
    logic [N-1:0]  q_in;
    logic [IW-1:0] idx;
    logic          valid;
    logic          locked;
    logic          wrap;
    logic          seq_err;
    logic          illegal;
    logic [7:0]    err_cnt;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    johnson_code_monitor #(.N(N), .LOCK_LEN(2)) dut (
        .CLK     (clk),
        .CLR     (clr),
        .EN      (en),
        .Q_IN    (q_in),
        .IDX     (idx),
        .VALID   (valid),
        .LOCKED  (locked),
        .WRAP    (wrap),
        .SEQ_ERR (seq_err),
        .ILLEGAL (illegal),
        .ERR_CNT (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".idx"},     int'(idx),     int'(e.idx));
        check({tag, ".valid"},   int'(valid),   int'(e.valid));
        check({tag, ".locked"},  int'(locked),  int'(e.locked));
        check({tag, ".wrap"},    int'(wrap),    int'(e.wrap));
        check({tag, ".seq_err"}, int'(seq_err), int'(e.seq_err));
        check({tag, ".illegal"}, int'(illegal), int'(e.illegal));
        check({tag, ".err_cnt"}, int'(err_cnt), int'(e.cnt));
    endtask

    // Drive one sample and queue its expected registered response.
    task automatic step(input logic e_n, input logic [N-1:0] q,
                        input int x_idx, input logic x_v, input logic x_l,
                        input logic x_w, input logic x_s, input logic x_i,
                        input int x_cnt);
        exp_t e;
        @(negedge clk);
        en   = e_n;
        q_in = q;
        e.idx     = IW'(x_idx);
        e.valid   = x_v;
        e.locked  = x_l;
        e.wrap    = x_w;
        e.seq_err = x_s;
        e.illegal = x_i;
        e.cnt     = 8'(x_cnt);
        sb_q.push_back(e);
    endtask

    // Monitor: every rising edge presents a response; compare if one is due.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) check_all("edge", sb_q.pop_front());
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] cyc [8];
        exp_t zero_e;
        cyc[0] = 4'b1111; cyc[1] = 4'b1110; cyc[2] = 4'b1100; cyc[3] = 4'b1000;
        cyc[4] = 4'b0000; cyc[5] = 4'b0001; cyc[6] = 4'b0011; cyc[7] = 4'b0111;
        zero_e = '{idx: '0, valid: 0, locked: 0, wrap: 0, seq_err: 0, illegal: 0, cnt: 0};

        clr  = 1'b1;
        en   = 1'b0;
        q_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", zero_e);
        clr = 1'b0;

        // Lock-in
        step(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0001, 1, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0011, 2, 1, 1, 0, 0, 0, 0);
        step(1, 4'b0111, 3, 1, 1, 0, 0, 0, 0);

        // Two full cycles while locked; index 4..7 then 0..3, wrap on 0000
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 8; k++) begin
                step(1, cyc[k], (k + 4) % 8, 1, 1, (k == 4), 0, 0, 0);
            end
        end

        // Illegal code, then re-lock
        step(1, 4'b0101, 3, 0, 0, 0, 0, 1, 1);
        step(1, 4'b0000, 0, 1, 0, 0, 0, 0, 1);
        step(1, 4'b0001, 1, 1, 0, 0, 0, 0, 1);
        step(1, 4'b0011, 2, 1, 1, 0, 0, 0, 1);

        // Skip 0111 -> sequence error, re-lock on 1100
        step(1, 4'b1111, 4, 1, 0, 0, 1, 0, 2);
        step(1, 4'b1110, 5, 1, 0, 0, 0, 0, 2);
        step(1, 4'b1100, 6, 1, 1, 0, 0, 0, 2);

        // Enable gating with junk on the bus
        step(0, 4'b0101, 6, 1, 1, 0, 0, 0, 2);
        step(0, 4'b1111, 6, 1, 1, 0, 0, 0, 2);
        step(0, 4'b0000, 6, 1, 1, 0, 0, 0, 2);
        step(1, 4'b1000, 7, 1, 1, 0, 0, 0, 2);
        // Stall: same code again
        step(1, 4'b1000, 7, 1, 0, 0, 1, 0, 3);

        // Asynchronous clear between edges
        @(negedge clk);
        en   = 1'b0;
        clr  = 1'b1;
        #1;
        check_all("async_clr", zero_e);
        sb_q.push_back(zero_e);
        @(negedge clk);
        clr = 1'b0;
        sb_q.push_back(zero_e);

        // Saturation of the error counter
        for (int i = 0; i < 300; i++) begin
            step(1, 4'b0101, 0, 0, 0, 0, 0, 1, (i + 1 > 255) ? 255 : i + 1);
        end

        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #2;
        check("sb_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/johnson_code_monitor.md
# johnson_code_monitor

Receive-side companion to the Johnson counter. It samples an N-bit Johnson code each enabled clock and decodes it to a binary state index. It checks that the code is legal and that each sample is the correct successor of the previous one, and reports lock, wrap and error status. It sits downstream of a Johnson counter, or of any bus carrying Johnson-coded state, as a decoder and integrity checker.

## Interface
- N, default 4: code width in bits; sequence length is 2N; N ≥ 2.
- LOCK_LEN, default 2: number of consecutive correct successors needed to declare lock; LOCK_LEN ≥ 1.
- CLK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- EN  in  1  sample enable; Q_IN is sampled only on edges where EN=1.
- Q_IN  in  N  Johnson code under test.
- IDX  out  $clog2(2N)  decoded index (0..2N-1) of the last legal sample.
- VALID  out  1  1 when the last sample was legal.
- LOCKED  out  1  1 while the FSM is in TRACK.
- WRAP  out  1  one-cycle pulse when the all-zeros code is sampled in TRACK as the expected successor.
- SEQ_ERR  out  1  one-cycle pulse when a legal but unexpected code is sampled in TRACK.
- ILLEGAL  out  1  one-cycle pulse when a non-Johnson code is sampled, in any state.
- ERR_CNT  out  8  saturating count of SEQ_ERR and ILLEGAL events.

## Operation
- Sequence definition: next(Q) = {Q[N-2:0], ~Q[N-1]}. For N=4 this gives 0000→0001→0011→0111→1111→1110→1100→1000→0000.
- Legality: Q is legal when at most one adjacent pair (Q[i], Q[i+1]), i=0..N-2, differs. This yields exactly 2N legal codes.
- Decode:
  - Q[N-1]=0 → IDX = popcount(Q).
  - Q[N-1]=1 → IDX = N + popcount(~Q).
- FSM states IDLE, HUNT, TRACK, plus expected-code register EXP and match counter MCNT. On each sampled edge:
  - IDLE, legal sample → HUNT; EXP=next(Q); MCNT=0.
  - IDLE, illegal sample → stay in IDLE.
  - HUNT, Q==EXP → MCNT+1 and EXP=next(Q). If MCNT+1==LOCK_LEN → TRACK.
  - HUNT, legal but ≠EXP → stay in HUNT; EXP=next(Q); MCNT=0; no SEQ_ERR.
  - HUNT or TRACK, illegal sample → IDLE.
  - TRACK, Q==EXP → stay in TRACK; EXP=next(Q).
  - TRACK, legal but ≠EXP → SEQ_ERR pulse; HUNT; EXP=next(Q); MCNT=0. A repeated (stalled) code counts as ≠EXP.
- Output rules:
  - Legal sample: IDX updated, VALID=1.
  - Illegal sample: ILLEGAL pulse, VALID=0, IDX holds its previous value.
  - ERR_CNT increments by 1 per SEQ_ERR or ILLEGAL event and saturates at 255. SEQ_ERR and ILLEGAL cannot occur on the same sample.
- EN=0: no sampling; FSM, EXP, MCNT, IDX, VALID, LOCKED and ERR_CNT hold; all pulse outputs are 0.

## Timing
- All outputs are registered. Latency is one cycle: effects of the sample taken at edge k are visible immediately after edge k.
- Pulses (WRAP, SEQ_ERR, ILLEGAL) are high for exactly one cycle. They deassert on the next edge regardless of EN.
- LOCKED rises at the edge of the LOCK_LEN-th correct successor. It falls at the edge of the first error.
- Reset values: IDX=0, VALID=0, LOCKED=0, WRAP=0, SEQ_ERR=0, ILLEGAL=0, ERR_CNT=0, FSM=IDLE, EXP=0, MCNT=0.
- CLR asserted mid-operation clears every output immediately, without waiting for a clock edge. The first sampled edge after CLR falls is treated as a sample in IDLE.

## Structure
- Package johnson_pkg holds:
  - FSM state enum (IDLE, HUNT, TRACK);
  - functions johnson_next, johnson_legal, johnson_index, parameterised by N;
  - ERR_CNT_MAX = 255.
- Sub-module johnson_decode: combinational, Q_IN → legal flag + index. The monitor instantiates it once. The module is reusable wherever Johnson state must be read back.

## Test plan
All scenarios use N=4, LOCK_LEN=2.
- Lock-in: after CLR, apply EN=1 with Q_IN 0000, 0001, 0011, 0111 on successive edges → IDX 0,1,2,3; VALID=1 from the first edge; LOCKED=1 from the third edge onward.
- Full wrap: run two complete 8-state cycles while locked → IDX for 1111,1110,1100,1000 is 4,5,6,7; WRAP pulses exactly once per 0000 sample in TRACK; ERR_CNT=0.
- Illegal code: while locked, apply 0101 → ILLEGAL pulse; VALID=0; IDX holds 3; LOCKED=0; ERR_CNT=1. Then 0000, 0001, 0011 → LOCKED returns on the 0011 edge.
- Skip: while locked after 0011, apply 1111 → SEQ_ERR pulse; IDX=4; LOCKED=0; ERR_CNT+1. Then 1110, 1100 → relocks on 1100.
- Enable gating and stall: while locked, hold EN=0 for 3 edges with junk on Q_IN → all outputs hold, no pulses; resume with the expected code → stays locked. Then repeat the same code twice → SEQ_ERR.
- Reset and saturation: assert CLR between edges mid-run → all outputs 0 before the next edge. Then apply 300 illegal samples → ERR_CNT stops at 255.
